// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants, IF/ID register layout and instruction field positions.
package cpu_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;
    localparam int RD_MSB = 15;
    localparam int RD_LSB = 11;
    localparam int SHAMT_MSB = 10;
    localparam int SHAMT_LSB = 6;
    localparam int IMM16_MSB = 15;
    localparam int IMM16_LSB = 0;
    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc4;
        logic            valid;
    } ifid_t;
    localparam ifid_t IFID_BUBBLE = '{NOP_INST, '0, 1'b0};
    function automatic logic [XLEN-1:0] br_offset(input logic [IMM16_MSB:IMM16_LSB] imm);
        return {{(XLEN-18){imm[15]}}, imm, 2'b00};
    endfunction
endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: fetch-stage bus (instruction memory, hazard/branch inputs, IF/ID outputs).
interface if_stage_if;
    import cpu_pkg::*;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_data;
    logic            stall;
    logic            br_taken;
    logic [XLEN-1:0] br_pc4;
    logic [15:0]     br_imm16;
    logic [XLEN-1:0] ifid_inst;
    logic [XLEN-1:0] ifid_pc4;
    logic            ifid_valid;
    modport master (
        output imem_addr, ifid_inst, ifid_pc4, ifid_valid,
        input  imem_data, stall, br_taken, br_pc4, br_imm16
    );
    modport slave (
        input  imem_addr, ifid_inst, ifid_pc4, ifid_valid,
        output imem_data, stall, br_taken, br_pc4, br_imm16
    );
endinterface

// File: rtl/br_target_calc.sv
// br_target_calc: taken-branch target = branch pc4 + sign-extended word offset, modulo 2^32.
module br_target_calc
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0] pc4_i,
    input  logic [15:0]     imm16_i,
    output logic [XLEN-1:0] target_o
);
    assign target_o = pc4_i + br_offset(imm16_i);
endmodule

// File: rtl/if_stage.sv
// if_stage: program counter, instruction fetch and IF/ID register with stall and branch redirect.
// IF_DELAY_SLOT_EN: taken branches load the delay-slot instruction instead of a bubble.
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic clk,
    input  logic rst_n,
    if_stage_if.master bus
);
    logic [XLEN-1:0] pc_q, pc_d, pc4, target;
    ifid_t ifid_q, ifid_d, seq_load, br_load;

    br_target_calc u_br_target_calc (
        .pc4_i    (bus.br_pc4),
        .imm16_i  (bus.br_imm16),
        .target_o (target)
    );

    always_comb begin
        pc4 = pc_q + 32'd4;
        seq_load = '{bus.imem_data, pc4, 1'b1};
`ifdef IF_DELAY_SLOT_EN
        br_load = seq_load;
`else
        br_load = IFID_BUBBLE;
`endif
        // stall wins over br_taken; hazard logic holds br_taken until stall drops
        pc_d = bus.stall ? pc_q : bus.br_taken ? target : pc4;
        ifid_d = bus.stall ? ifid_q : bus.br_taken ? br_load : seq_load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
            ifid_q <= IFID_BUBBLE;
        end else begin
            pc_q <= pc_d;
            ifid_q <= ifid_d;
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.ifid_inst = ifid_q.inst;
    assign bus.ifid_pc4 = ifid_q.pc4;
    assign bus.ifid_valid = ifid_q.valid;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed self-checking bench for if_stage; imem returns word = address.
module tb_if_stage;
    logic clk = 1'b0;
    logic rst_n;
    int total = 0;
    int bad = 0;
`ifdef IF_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    if_stage_if bus ();
    if_stage #(.RESET_PC(32'h0000_0000)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    assign bus.imem_data = bus.imem_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_all(input string tag, input logic [31:0] addr, input logic [31:0] inst,
                              input logic [31:0] pc4, input logic valid);
        check({tag, ".addr"}, bus.imem_addr, addr);
        check({tag, ".inst"}, bus.ifid_inst, inst);
        check({tag, ".pc4"}, bus.ifid_pc4, pc4);
        check({tag, ".valid"}, {31'd0, bus.ifid_valid}, {31'd0, valid});
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.stall = 1'b0;
        bus.br_taken = 1'b0;
        bus.br_pc4 = '0;
        bus.br_imm16 = '0;
        cyc();
        cyc();
        expect_all("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        rst_n = 1'b1;
        cyc(); expect_all("run0", 32'h4, 32'h0, 32'h4, 1'b1);
        cyc(); expect_all("run1", 32'h8, 32'h4, 32'h8, 1'b1);
        cyc(); expect_all("run2", 32'hC, 32'h8, 32'hC, 1'b1);
        cyc(); expect_all("run3", 32'h10, 32'hC, 32'h10, 1'b1);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(); expect_all($sformatf("stall%0d", i), 32'h10, 32'hC, 32'h10, 1'b1);
        end
        bus.stall = 1'b0;
        cyc(); expect_all("resume", 32'h14, 32'h10, 32'h14, 1'b1);
        bus.br_taken = 1'b1;
        bus.br_pc4 = 32'h20;
        bus.br_imm16 = 16'hFFFC;
        cyc(); expect_all("redir", 32'h10, DS ? 32'h14 : 32'h0, DS ? 32'h18 : 32'h0, DS);
        bus.br_taken = 1'b0;
        cyc(); expect_all("tgt", 32'h14, 32'h10, 32'h14, 1'b1);
        bus.stall = 1'b1;
        bus.br_taken = 1'b1;
        bus.br_pc4 = 32'h100;
        bus.br_imm16 = 16'h0004;
        cyc(); expect_all("sbr0", 32'h14, 32'h10, 32'h14, 1'b1);
        cyc(); expect_all("sbr1", 32'h14, 32'h10, 32'h14, 1'b1);
        bus.stall = 1'b0;
        cyc(); expect_all("sbr_go", 32'h110, DS ? 32'h14 : 32'h0, DS ? 32'h18 : 32'h0, DS);
        bus.br_pc4 = 32'h0;
        bus.br_imm16 = 16'hFFFF;
        cyc(); expect_all("to_top", 32'hFFFF_FFFC, DS ? 32'h110 : 32'h0, DS ? 32'h114 : 32'h0, DS);
        bus.br_taken = 1'b0;
        cyc(); expect_all("wrap", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1);
        cyc(); expect_all("post_wrap", 32'h4, 32'h0, 32'h4, 1'b1);
        bus.br_taken = 1'b1;
        bus.br_pc4 = 32'h40;
        bus.br_imm16 = 16'h0;
        #1 rst_n = 1'b0;
        #1 expect_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
        cyc(); expect_all("rst_hold", 32'h0, 32'h0, 32'h0, 1'b0);
        bus.br_taken = 1'b0;
        rst_n = 1'b1;
        cyc(); expect_all("rst_run", 32'h4, 32'h0, 32'h4, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
